// File: rtl/dec_ascii_pkg.sv
// Shared constants, FSM states and digit-count sizing helper for the
// binary-to-decimal ASCII converter.
package dec_ascii_pkg;

    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_MINUS = 8'h2D;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_FORMAT,
        ST_HOLD
    } state_e;

    // Decimal digits needed for the largest magnitude the input can carry.
    function automatic int MIN_DIGITS(input int width, input int is_signed);
        longint unsigned v;
        int              n;
        v = (is_signed != 0) ? (64'd1 << (width - 1)) : ((64'd1 << width) - 64'd1);
        n = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_add3_shift.sv
// One double-dabble step: add-3 correction on every BCD digit in parallel,
// then shift the whole vector left by one taking i_bit into the units LSB.
module bcd_add3_shift #(
    parameter int DIGITS = 4
) (
    input  logic [4*DIGITS-1:0] i_bcd,
    input  logic                i_bit,
    output logic [4*DIGITS-1:0] o_bcd
);

    logic [DIGITS-1:0] w_cy;

    assign w_cy[0] = i_bit;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        logic [3:0] w_d;
        assign w_d = i_bcd[4*g+:4];
        if (g == DIGITS - 1) begin : g_top
            // Digit count is sized for the input, so the top digit never carries out.
            assign o_bcd[4*g+:4] = {3'((w_d >= 4'd5) ? w_d + 4'd3 : w_d), w_cy[g]};
        end else begin : g_low
            logic [3:0] w_a;
            assign w_a           = (w_d >= 4'd5) ? w_d + 4'd3 : w_d;
            assign w_cy[g+1]     = w_a[3];
            assign o_bcd[4*g+:4] = {w_a[2:0], w_cy[g]};
        end
    end

endmodule

// File: rtl/bin_to_dec_ascii.sv
// Binary (signed/unsigned) to fixed-width decimal ASCII field, one bit per
// cycle double-dabble, with optional leading-zero blanking and sign slot.
module bin_to_dec_ascii
    import dec_ascii_pkg::*;
#(
    parameter int WIDTH    = 12,
    parameter int DIGITS   = 4,
    parameter int SIGNED   = 0,
    parameter int BLANK_LZ = 0
) (
    input  logic                         clk,
    input  logic                         rst_ni,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_value,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [8*(DIGITS+SIGNED)-1:0] out_ascii,
    output logic                         busy
);

    localparam int NCH   = DIGITS + SIGNED;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
        $error("bin_to_dec_ascii: WIDTH %0d outside 4..32", WIDTH);
    end
    if (DIGITS < MIN_DIGITS(WIDTH, SIGNED)) begin : g_bad_digits
        $error("bin_to_dec_ascii: DIGITS %0d < required %0d", DIGITS, MIN_DIGITS(WIDTH, SIGNED));
    end

    // Character 0 is the units digit (LSBs of the field); sign slot is character DIGITS.
    function automatic logic [8*NCH-1:0] fmt(input logic [4*DIGITS-1:0] bcd, input logic neg);
        logic [NCH-1:0][7:0] ch;
        logic [7:0]          sgn;
        int                  msnz;
        msnz = 0;
        sgn  = neg ? CH_MINUS : CH_SPACE;
        for (int i = 0; i < NCH; i++) ch[i] = CH_SPACE;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i+:4] != 4'd0) msnz = i;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (BLANK_LZ == 0 || i <= msnz) ch[i] = CH_ZERO + {4'h0, bcd[4*i+:4]};
        end
        if (SIGNED != 0) begin
            for (int k = 1; k < NCH; k++) begin
                if ((BLANK_LZ == 0) ? (k == NCH - 1) : (k == msnz + 1)) ch[k] = sgn;
            end
        end
        return ch;
    endfunction

    localparam logic [8*NCH-1:0] RST_FIELD = fmt({4*DIGITS{1'b0}}, 1'b0);

    state_e               r_state, w_state_nxt;
    logic [WIDTH-1:0]     r_shift;
    logic [4*DIGITS-1:0]  r_bcd;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg;
    logic [8*NCH-1:0]     r_ascii;

    logic                 w_neg;
    logic [WIDTH-1:0]     w_mag;
    logic [4*DIGITS-1:0]  w_bcd_nxt;
    logic [8*NCH-1:0]     w_field;

    // Most-negative input negates to itself, which read unsigned is the right magnitude.
    assign w_neg   = (SIGNED != 0) && in_value[WIDTH-1];
    assign w_mag   = w_neg ? (~in_value + WIDTH'(1)) : in_value;
    assign w_field = fmt(r_bcd, r_neg);

    bcd_add3_shift #(
        .DIGITS (DIGITS)
    ) u_step (
        .i_bcd (r_bcd),
        .i_bit (r_shift[WIDTH-1]),
        .o_bcd (w_bcd_nxt)
    );

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (in_valid) w_state_nxt = ST_CONVERT;
            ST_CONVERT: if (r_cnt == LAST_BIT) w_state_nxt = ST_FORMAT;
            ST_FORMAT:  w_state_nxt = ST_HOLD;
            ST_HOLD:    if (out_ready) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_ascii <= RST_FIELD;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_shift <= w_mag;
                        r_neg   <= w_neg;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                    end
                end
                ST_CONVERT: begin
                    r_bcd   <= w_bcd_nxt;
                    r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                    r_cnt   <= r_cnt + 1'b1;
                end
                ST_FORMAT: r_ascii <= w_field;
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_HOLD);
    assign busy      = (r_state == ST_CONVERT) || (r_state == ST_FORMAT);
    assign out_ascii = r_ascii;

endmodule
